mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory between the fetch unit and the load/store unit.
- Sits between the core and the memory block. Drives that block's MemRead/MemWrite/MemAddress/WriteData and takes its ReadData.
- Serializes requests with a req/ack handshake, fixed data-over-fetch priority and a fetch anti-starvation counter.
- One memory access per grant; no pipelining.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; the next grant is forced to fetch. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_ack  out  1  one-cycle completion pulse for fetch
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1
- if_err  out  1  fetch error flag; qualified by if_ack
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load result; valid while d_ack=1; 0 for stores
- d_err  out  1  data error flag; qualified by d_ack
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe; memory writes on the clk edge ending the cycle
- MemAddress  out  ADDR_W  memory byte address
- WriteData  out  DATA_W  memory write data
- ReadData  in  DATA_W  memory combinational read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset/IDLE values:
  - state=IDLE, owner=none, starve_cnt=0
  - all acks, errs and strobes = 0
  - MemAddress=0, WriteData=0, if_rdata=0, d_rdata=0
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its addr/we/wdata into internal registers, go to ACCESS.
- Arbitration in IDLE:
  - Both requesting and starve_cnt < STARVE_LIMIT: data wins, starve_cnt += 1.
  - Both requesting and starve_cnt == STARVE_LIMIT: fetch wins.
  - Only one requesting: that one wins.
  - Any fetch grant, or if_req=0 in IDLE, clears starve_cnt. starve_cnt saturates and never wraps.
- ACCESS (exactly 1 cycle):
  - MemAddress/WriteData come from the latched fields.
  - Fetch: MemRead=1. Load: MemRead=1. Store: MemWrite=1.
  - At the closing edge: ReadData is registered into if_rdata or d_rdata (d_rdata=0 for stores). Go to RESP.
- RESP (1 cycle):
  - Owner's ack=1; strobes=0; no arbitration.
  - Next state IDLE.
  - Requester drops req or presents a new request in the cycle after ack.
- Timing:
  - Latency: req seen in IDLE at cycle N -> strobe at N+1 -> ack at N+2.
  - Peak throughput: 1 access per 3 cycles.
- Strobes and MemAddress decode only from registered state and latches; no combinational path from requester inputs to memory.
- MemWrite = (state==ACCESS) & latched_we & rst_n, so a reset asserted during ACCESS suppresses the write.
- Reset mid-operation: next edge forces IDLE; pending transaction dropped with no ack; requester re-issues.
- Requests asserted in ACCESS/RESP wait; no loss as long as req stays held.
- Address/data inputs that change while req is high before ack: ignored after latching.

Optional Feature:
- Macro: MEM_ARB_BOUNDS_CHECK_EN.
- Defined: in IDLE, the winning request is checked. Error if addr >= 256 (beyond 64 words) or addr[1:0] != 0.
  - Erroneous request: skips memory (no strobe in ACCESS), still takes 3 cycles, acks with err=1 and rdata=0.
  - starve_cnt is updated normally.
- Undefined: no check; if_err and d_err are tied 0; addresses pass through unchanged (memory aliases on addr[7:2]).

Test Plan:
- Fetch only: if_req=1, if_addr=0x04, memory word1=0x01210000 -> MemRead=1 at N+1, if_ack=1 at N+2 with if_rdata=0x01210000, if_err=0.
- Store then load: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF. After ack, issue load from 0x40 -> d_ack with d_rdata=0xDEADBEEF; MemWrite high exactly 1 cycle.
- Contention: if_req and d_req both held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; no simultaneous acks.
- Reset during ACCESS of store to 0x40 (old value 0): rst_n=0 that cycle -> MemWrite=0, no d_ack, word at 0x40 stays 0, all outputs 0 next cycle.
- With MEM_ARB_BOUNDS_CHECK_EN: load from 0x100 -> d_ack=1, d_err=1, d_rdata=0, MemRead never asserted. Fetch from 0x06 -> if_err=1.
- Idle bus: no requests for 10 cycles -> strobes, acks and MemAddress remain 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - unified memory arbiter between instruction fetch and load/store unit
// Optional address bounds/alignment checking is enabled by defining MEM_ARB_BOUNDS_CHECK_EN.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W-1:0] ReadData
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;
   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        owner;
   logic [3:0]        starve_cnt;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic              any_req;
   logic              grant_d;
   logic [ADDR_W-1:0] sel_addr;
   logic              mem_ok;
   logic [DATA_W-1:0] rd_val;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
   logic              lat_err;
   logic              sel_err;
`endif

   // Arbitration: data wins unless fetch has been passed over STARVE_LIMIT times in a row
   always_comb begin
      any_req  = if_req | d_req;
      grant_d  = d_req & (~if_req | (starve_cnt < LIMIT));
      sel_addr = grant_d ? d_addr : if_addr;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      sel_err  = ((sel_addr >> 8) != '0) || (sel_addr[1:0] != 2'b00);
      mem_ok   = ~lat_err;
`else
      mem_ok   = 1'b1;
`endif
      rd_val   = mem_ok ? ReadData : '0;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: one access per grant, fixed three-cycle walk
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = any_req ? ACCESS : IDLE;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latches, starvation counter and read-data capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner      <= OWN_NONE;
         starve_cnt <= '0;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
         lat_err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner     <= grant_d ? OWN_D : OWN_IF;
                  lat_addr  <= sel_addr;
                  lat_we    <= grant_d & d_we;
                  lat_wdata <= grant_d ? d_wdata : '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
                  lat_err   <= sel_err;
`endif
               end
               // Only a data grant that bypassed a waiting fetch counts; the branch
               // is reachable only below LIMIT, so the counter saturates by construction.
               if (if_req && grant_d) begin
                  starve_cnt <= starve_cnt + 4'd1;
               end else begin
                  starve_cnt <= '0;
               end
            end
            ACCESS: begin
               if (owner == OWN_IF) begin
                  if_rdata <= rd_val;
               end else begin
                  d_rdata  <= lat_we ? '0 : rd_val;
               end
            end
            RESP: begin
               owner    <= OWN_NONE;
               if_rdata <= '0;
               d_rdata  <= '0;
            end
            default: begin
               owner <= OWN_NONE;
            end
         endcase
      end
   end

   // Outputs decode from registered state and latches only
   always_comb begin
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemAddress = '0;
      WriteData  = '0;
      if_ack     = 1'b0;
      d_ack      = 1'b0;
      if_err     = 1'b0;
      d_err      = 1'b0;
      case (state)
         ACCESS: begin
            if (mem_ok) begin
               MemAddress = lat_addr;
               WriteData  = lat_wdata;
               MemRead    = ~lat_we;
               // Reset during the access cycle must suppress the write at this edge
               MemWrite   = lat_we & rst_n;
            end
         end
         RESP: begin
            if_ack = (owner == OWN_IF);
            d_ack  = (owner == OWN_D);
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            if_err = (owner == OWN_IF) & lat_err;
            d_err  = (owner == OWN_D) & lat_err;
`endif
         end
         default: begin
            MemRead = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard testbench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] MemAddress;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
      .WriteData(WriteData), .ReadData(ReadData)
   );

   // 64-word memory, combinational read, write on the edge closing the strobe cycle
   logic [31:0] mem [0:63];
   logic        poke_en;
   logic [5:0]  poke_idx;
   logic [31:0] poke_data;

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_data;
      else if (MemWrite) mem[MemAddress[7:2]] <= WriteData;
   end
   assign ReadData = mem[MemAddress[7:2]];

   typedef struct packed {
      logic        is_d;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   exp_t push_e;
   int   checks = 0;
   int   errors = 0;
   int   wr_cycles = 0;
   int   rd_cycles = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input int i);
      if (i == 0) return 32'hA5A50000;
      if (i == 1) return 32'h01210000;
      if (i >= 32 && i < 40) return 32'hD0000000 + 32'(i - 32);
      if (i == 48 || i == 49) return 32'hF0000000 + 32'(i - 48);
      return 32'h0;
   endfunction

   task automatic expect_resp(input logic is_d, input logic [31:0] rdata, input logic err);
      push_e = '{is_d: is_d, rdata: rdata, err: err};
      sb.push_back(push_e);
   endtask

   // Monitor: pops the scoreboard on every ack and counts strobe cycles
   always @(negedge clk) begin
      if (MemWrite) wr_cycles++;
      if (MemRead) rd_cycles++;
      if (mon_en && (if_ack || d_ack)) begin
         chk("ack_exclusive", 160'(if_ack & d_ack), 160'(0));
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected none", if_ack, d_ack);
         end else begin
            mon_e = sb.pop_front();
            chk("ack_owner_is_d", 160'(d_ack), 160'(mon_e.is_d));
            chk("ack_rdata", 160'(d_ack ? d_rdata : if_rdata), 160'(mon_e.rdata));
            chk("ack_err", 160'(d_ack ? d_err : if_err), 160'(mon_e.err));
         end
      end
   end

   // Single request from an IDLE cycle with fixed-latency checks of strobe and ack
   task automatic single(input logic is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_rd, input logic exp_wr,
                         input logic [31:0] exp_rdata, input logic exp_err);
      expect_resp(is_d, exp_rdata, exp_err);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      @(negedge clk);
      chk("idle_strobe", 160'({MemRead, MemWrite}), 160'(0));
      @(negedge clk);
      chk("access_strobe", 160'({MemRead, MemWrite}), 160'({exp_rd, exp_wr}));
      if (exp_rd || exp_wr) chk("access_addr", 160'(MemAddress), 160'(addr));
      if (exp_wr) chk("access_wdata", 160'(WriteData), 160'(wdata));
      @(negedge clk);
      chk("resp_ack", 160'({if_ack, d_ack}), is_d ? 160'(2'b01) : 160'(2'b10));
      chk("resp_strobe", 160'({MemRead, MemWrite}), 160'(0));
      @(posedge clk); #1;
      if_req = 1'b0;
      d_req  = 1'b0;
   endtask

   task automatic wait_ack(input logic is_d, input string name);
      logic got;
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         got = is_d ? d_ack : if_ack;
         if (got) break;
      end
      chk(name, 160'(got), 160'(1));
   endtask

   initial begin
      int wr0;
      int rd0;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      poke_en = 1'b0; poke_idx = '0; poke_data = '0;

      // Memory preload while reset is held
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         poke_idx = 6'(i); poke_data = init_val(i); poke_en = 1'b1;
      end
      @(negedge clk);
      poke_en = 1'b0;
      chk("reset_outputs",
          160'({if_ack, if_err, d_ack, d_err, MemRead, MemWrite, MemAddress, WriteData, if_rdata, d_rdata}),
          160'(0));
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Idle bus
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_bus", 160'({MemRead, MemWrite, if_ack, d_ack, MemAddress}), 160'(0));
      end
      @(posedge clk); #1;

      // Fetch only
      single(1'b0, 1'b0, 32'h04, 32'h0, 1'b1, 1'b0, 32'h01210000, 1'b0);

      // Reset during the access cycle of a store
      wr0 = wr_cycles;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_access_memwrite", 160'(MemWrite), 160'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("rst_after_outputs",
          160'({if_ack, if_err, d_ack, d_err, MemRead, MemWrite, MemAddress, WriteData, if_rdata, d_rdata}),
          160'(0));
      chk("rst_mem_unchanged", 160'(mem[16]), 160'(0));
      chk("rst_no_write_cycle", 160'(wr_cycles - wr0), 160'(0));
      @(posedge clk); #1;

      // Store then load
      wr0 = wr_cycles;
      single(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("store_write_pulse", 160'(wr_cycles - wr0), 160'(1));
      chk("store_mem", 160'(mem[16]), 160'(32'hDEADBEEF));
      single(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);

      // Out-of-range and misaligned requests
      rd0 = rd_cycles;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      single(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("oob_no_read", 160'(rd_cycles - rd0), 160'(0));
      single(1'b0, 1'b0, 32'h06, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
`else
      single(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hA5A50000, 1'b0);
      chk("alias_one_read", 160'(rd_cycles - rd0), 160'(1));
      single(1'b0, 1'b0, 32'h06, 32'h0, 1'b1, 1'b0, 32'h01210000, 1'b0);
`endif

      // Contention: expected grant order D,D,D,D,F,D,D,D,D,F
      for (int i = 0; i < 4; i++) expect_resp(1'b1, 32'hD0000000 + 32'(i), 1'b0);
      expect_resp(1'b0, 32'hF0000000, 1'b0);
      for (int i = 4; i < 8; i++) expect_resp(1'b1, 32'hD0000000 + 32'(i), 1'b0);
      expect_resp(1'b0, 32'hF0000001, 1'b0);
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80 + 32'(4 * i);
               wait_ack(1'b1, "cont_d_ack");
               @(posedge clk); #1;
            end
            d_req = 1'b0;
         end
         begin
            for (int j = 0; j < 2; j++) begin
               if_req = 1'b1; if_addr = 32'hC0 + 32'(4 * j);
               wait_ack(1'b0, "cont_f_ack");
               @(posedge clk); #1;
            end
            if_req = 1'b0;
         end
      join

      repeat (4) @(negedge clk);
      chk("sb_drained", 160'(sb.size()), 160'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
